vadd_wb_stage: RTL and testbench
================================

Name: vadd_wb_stage

Overview:
- Writeback stage directly downstream of the SIMD integer adder in the vector lane.
- Consumes the raw per-slot sum and carry-outs and performs a masked merge with the old destination value.
- For carry-out ops (vmadc/vmsbc class), packs the per-element carry-outs into mask-register format.
- Registers the result behind a 2-entry elastic buffer with a valid/ready handshake toward the lane's register-file write port.

Parameters:
- MIN_WIDTH, 8: smallest element width in bits (one slot).
- MAX_WIDTH, 64: datapath width in bits.
- SEW_WIDTH, $clog2(MAX_WIDTH/MIN_WIDTH)+1: width of the one-hot SEW code.
- TAG_W, 5: width of the destination register tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous flush; drops all buffered entries.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept a beat.
- op_i  in  1  0 = ARITH (merge sum), 1 = CARRYOUT (pack carries).
- sew_i  in  SEW_WIDTH  one-hot SEW; bit k = element width MIN_WIDTH<<k.
- mask_i  in  N  element enables; bit e enables element e. N = MAX_WIDTH/MIN_WIDTH.
- sum_i  in  MAX_WIDTH  adder result.
- cout_i  in  N  adder per-slot carry-outs.
- old_vd_i  in  MAX_WIDTH  current destination contents.
- tag_i  in  TAG_W  destination tag.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- data_o  out  MAX_WIDTH  merged write data.
- wbe_o  out  N  byte-slot write enables.
- tag_o  out  TAG_W  destination tag.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset: valid_o=0, data_o=0, wbe_o=0, tag_o=0, buffer EMPTY. ready_o=1 on the first cycle after rst_n rises. Reset mid-operation discards all entries.
- SEW decode: k = index of the lowest set bit of sew_i; all-zero decodes to k=0. Element count E = N>>k; element e spans slots [e<<k, ((e+1)<<k)-1].
- ARITH:
  - Element e of data_o = mask_i[e] ? sum_i element : old_vd_i element.
  - Only mask_i[E-1:0] are used.
  - wbe_o = all ones.
- CARRYOUT:
  - For e<E, data_o[e] = mask_i[e] ? cout_i[((e+1)<<k)-1] : old_vd_i[e].
  - For e>=E, data_o[e] = old_vd_i[e]; bits N..MAX_WIDTH-1 also equal old_vd_i.
  - wbe_o = bytes covering bits 0..N-1 only (N=8 gives 8'h01).
- Computation is combinational on the input side. The result is written into the buffer on accept (valid_i & ready_o). Latency is 1 cycle from accept to valid_o when the buffer is empty.
- Buffer FSM:
  - States: EMPTY, ONE, FULL.
  - ready_o = (state != FULL), driven from a registered state. valid_o = (state != EMPTY).
  - push only: EMPTY→ONE, ONE→FULL.
  - pop only (valid_o & ready_i): FULL→ONE, ONE→EMPTY.
  - push and pop together in ONE: stays ONE; the head is replaced by the new entry.
  - push is impossible in FULL because ready_o=0.
- Order is strict FIFO. data_o, wbe_o and tag_o are held stable while valid_o & !ready_i.
- flush_i has priority over push and pop. The next state is EMPTY, the incoming beat is dropped, and any output transfer in that cycle still counts as consumed.

Decomposition:
- Package vadd_pkg:
  - enum vadd_wb_op_e {ARITH, CARRYOUT}.
  - struct vadd_wb_entry_t {data, wbe, tag}.
  - function sew_index(sew) returning the lowest-set-bit index.
- Sub-module vadd_wb_skid: a generic 2-entry elastic buffer parameterized by payload type, implementing the FSM above plus flush.
- Merge/pack logic stays inline in vadd_wb_stage.

Test Plan (MAX_WIDTH=64, MIN_WIDTH=8):
1. ARITH, sew_i=4'b0100, sum_i=64'h1111_1111_2222_2222, old_vd_i=64'hAAAA_AAAA_BBBB_BBBB, mask_i=8'h01, ready_i=1 → next cycle valid_o=1, data_o=64'hAAAA_AAAA_2222_2222, wbe_o=8'hFF.
2. CARRYOUT, sew_i=4'b0001, cout_i=8'hA5, mask_i=8'hFF, old_vd_i=64'hFFFF_FFFF_FFFF_FF00 → data_o=64'hFFFF_FFFF_FFFF_FFA5, wbe_o=8'h01.
3. CARRYOUT, sew_i=4'b0010, cout_i=8'b1000_0010, mask_i=8'h05, old_vd_i=64'h0000_0000_0000_00F0 → data_o=64'h0000_0000_0000_00F1, wbe_o=8'h01.
4. ready_i=0, upstream drives beats A,B,C back-to-back → A and B accepted; ready_o=0 from the cycle after B until a pop. Raising ready_i yields A,B,C in order with no loss or duplication, and outputs stay stable while stalled.
5. Buffer FULL, flush_i=1 with valid_i=1 in the same cycle → next cycle valid_o=0, ready_o=1, the incoming beat never appears on the output.
6. Buffer FULL, rst_n=0 for one cycle → valid_o=0, data_o=0, wbe_o=0; a subsequent single beat emerges after 1 cycle.

Source files
------------

// File: rtl/vadd_pkg.sv
// Shared types and helpers for the vector-add writeback stage.
package vadd_pkg;

  localparam int unsigned VADD_MIN_WIDTH = 8;
  localparam int unsigned VADD_MAX_WIDTH = 64;
  localparam int unsigned VADD_N         = VADD_MAX_WIDTH / VADD_MIN_WIDTH;
  localparam int unsigned VADD_SEW_WIDTH = $clog2(VADD_N) + 1;
  localparam int unsigned VADD_TAG_W     = 5;

  typedef enum logic {
    ARITH    = 1'b0,
    CARRYOUT = 1'b1
  } vadd_wb_op_e;

  typedef struct packed {
    logic [VADD_MAX_WIDTH-1:0] data;
    logic [VADD_N-1:0]         wbe;
    logic [VADD_TAG_W-1:0]     tag;
  } vadd_wb_entry_t;

  // All-zero SEW falls back to the narrowest element width.
  function automatic int unsigned sew_index(input logic [VADD_SEW_WIDTH-1:0] sew);
    int unsigned idx;
    idx = 0;
    for (int i = VADD_SEW_WIDTH - 1; i >= 0; i--) begin
      if (sew[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vadd_wb_skid.sv
// Two-entry elastic buffer, any packed payload; registered ready, flush drops everything.
module vadd_wb_skid #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_vld,
  output logic o_rdy,
  input  T     i_dat,
  output logic o_vld,
  input  logic i_rdy,
  output T     o_dat
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  T            r_head;
  T            r_tail;
  logic        w_push;
  logic        w_pop;

  assign o_rdy = (r_state != FULL);
  assign o_vld = (r_state != EMPTY);
  assign o_dat = r_head;

  always_comb begin
    w_push      = i_vld & o_rdy & ~i_flush;
    w_pop       = o_vld & i_rdy;
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_push) w_state_nxt = ONE;
        ONE:     if (w_push && !w_pop) w_state_nxt = FULL;
                 else if (!w_push && w_pop) w_state_nxt = EMPTY;
        FULL:    if (w_pop) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Head always holds the oldest entry so the output needs no mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_flush) begin
      case (r_state)
        EMPTY: if (w_push) r_head <= i_dat;
        ONE: begin
          if (w_push && w_pop) r_head <= i_dat;
          else if (w_push)     r_tail <= i_dat;
        end
        FULL:    if (w_pop) r_head <= r_tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vadd_wb_stage.sv
// Masked merge / carry packing of adder results, buffered toward the RF write port.
module vadd_wb_stage
  import vadd_pkg::*;
#(
  parameter int unsigned MIN_WIDTH = VADD_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH = VADD_MAX_WIDTH,
  parameter int unsigned SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
  parameter int unsigned TAG_W     = VADD_TAG_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic                           op_i,
  input  logic [SEW_WIDTH-1:0]           sew_i,
  input  logic [MAX_WIDTH/MIN_WIDTH-1:0] mask_i,
  input  logic [MAX_WIDTH-1:0]           sum_i,
  input  logic [MAX_WIDTH/MIN_WIDTH-1:0] cout_i,
  input  logic [MAX_WIDTH-1:0]           old_vd_i,
  input  logic [TAG_W-1:0]               tag_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [MAX_WIDTH-1:0]           data_o,
  output logic [MAX_WIDTH/MIN_WIDTH-1:0] wbe_o,
  output logic [TAG_W-1:0]               tag_o
);

  localparam int unsigned N        = MAX_WIDTH / MIN_WIDTH;
  localparam int unsigned CO_BYTES = (N + 7) / 8;

  int unsigned          w_k;
  logic [MAX_WIDTH-1:0] w_data;
  logic [N-1:0]         w_wbe;
  vadd_wb_entry_t       w_in;
  vadd_wb_entry_t       w_out;

  always_comb begin
    w_k    = sew_index(sew_i);
    w_data = old_vd_i;
    w_wbe  = '0;
    if (vadd_wb_op_e'(op_i) == CARRYOUT) begin
      // Carry of element e is the carry out of its top slot.
      w_wbe[CO_BYTES-1:0] = '1;
      for (int unsigned kk = 0; kk < SEW_WIDTH; kk++) begin
        if (w_k == kk) begin
          for (int unsigned e = 0; e < (N >> kk); e++) begin
            if (mask_i[e]) w_data[e] = cout_i[((e + 1) << kk) - 1];
          end
        end
      end
    end else begin
      w_wbe = '1;
      for (int unsigned kk = 0; kk < SEW_WIDTH; kk++) begin
        if (w_k == kk) begin
          for (int unsigned s = 0; s < N; s++) begin
            if (mask_i[s >> kk])
              w_data[s*MIN_WIDTH +: MIN_WIDTH] = sum_i[s*MIN_WIDTH +: MIN_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    w_in      = '0;
    w_in.data = w_data;
    w_in.wbe  = w_wbe;
    w_in.tag  = tag_i;
  end

  vadd_wb_skid #(
    .T(vadd_wb_entry_t)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(flush_i),
    .i_vld  (valid_i),
    .o_rdy  (ready_o),
    .i_dat  (w_in),
    .o_vld  (valid_o),
    .i_rdy  (ready_i),
    .o_dat  (w_out)
  );

  assign data_o = w_out.data;
  assign wbe_o  = w_out.wbe;
  assign tag_o  = w_out.tag;

endmodule

// File: tb/tb_vadd_wb_stage.sv
// Directed self-checking bench for vadd_wb_stage.
module tb_vadd_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic        op_i;
  logic [3:0]  sew_i;
  logic [7:0]  mask_i;
  logic [63:0] sum_i;
  logic [7:0]  cout_i;
  logic [63:0] old_vd_i;
  logic [4:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic [7:0]  wbe_o;
  logic [4:0]  tag_o;

  int n_checks = 0;
  int n_fail   = 0;

  vadd_wb_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .sew_i   (sew_i),
    .mask_i  (mask_i),
    .sum_i   (sum_i),
    .cout_i  (cout_i),
    .old_vd_i(old_vd_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .wbe_o   (wbe_o),
    .tag_o   (tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; outputs are sampled at negedge before new drive.
  task automatic drive(input logic op, input logic [3:0] sew, input logic [7:0] mask,
                       input logic [63:0] sum, input logic [7:0] cout,
                       input logic [63:0] old, input logic [4:0] tag);
    valid_i  = 1'b1;
    op_i     = op;
    sew_i    = sew;
    mask_i   = mask;
    sum_i    = sum;
    cout_i   = cout;
    old_vd_i = old;
    tag_i    = tag;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    op_i = 1'b0; sew_i = 4'b0001; mask_i = '0; sum_i = '0; cout_i = '0;
    old_vd_i = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_checks++; if (data_o !== 64'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_o); end
    n_checks++; if (wbe_o !== 8'h00) begin n_fail++; $display("FAIL reset_wbe got=%h exp=00", wbe_o); end
    n_checks++; if (tag_o !== 5'h00) begin n_fail++; $display("FAIL reset_tag got=%h exp=00", tag_o); end
  endtask

  task automatic test_arith;
    ready_i = 1'b1;
    drive(1'b0, 4'b0100, 8'h01, 64'h1111_1111_2222_2222, 8'h00, 64'hAAAA_AAAA_BBBB_BBBB, 5'd3);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL arith_valid got=%b exp=1", valid_o); end
    n_checks++; if (data_o !== 64'hAAAA_AAAA_2222_2222) begin n_fail++; $display("FAIL arith_data got=%h exp=aaaaaaaa22222222", data_o); end
    n_checks++; if (wbe_o !== 8'hFF) begin n_fail++; $display("FAIL arith_wbe got=%h exp=ff", wbe_o); end
    n_checks++; if (tag_o !== 5'd3) begin n_fail++; $display("FAIL arith_tag got=%0d exp=3", tag_o); end
    // 16-bit elements with two SEW bits set: lowest bit (k=1) wins; mask 0x5 picks elements 0 and 2.
    drive(1'b0, 4'b0110, 8'h05, 64'h1234_5678_9ABC_DEF0, 8'h00, 64'h0000_0000_0000_0000, 5'd4);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'h0000_5678_0000_DEF0) begin n_fail++; $display("FAIL arith_sew16 got=%h exp=000056780000def0", data_o); end
    // Single 64-bit element: only mask bit 0 matters.
    drive(1'b0, 4'b1000, 8'hFE, 64'h1111_1111_1111_1111, 8'h00, 64'h2222_2222_2222_2222, 5'd5);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'h2222_2222_2222_2222) begin n_fail++; $display("FAIL arith_sew64 got=%h exp=2222222222222222", data_o); end
    // All-zero SEW behaves as 8-bit elements.
    drive(1'b0, 4'b0000, 8'h81, 64'h1111_1111_1111_1111, 8'h00, 64'h2222_2222_2222_2222, 5'd6);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'h1122_2222_2222_2211) begin n_fail++; $display("FAIL arith_sew0 got=%h exp=1122222222222211", data_o); end
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL arith_drain got=%b exp=0", valid_o); end
  endtask

  task automatic test_carryout;
    ready_i = 1'b1;
    drive(1'b1, 4'b0001, 8'hFF, 64'h0, 8'hA5, 64'hFFFF_FFFF_FFFF_FF00, 5'd7);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'hFFFF_FFFF_FFFF_FFA5) begin n_fail++; $display("FAIL cout8_data got=%h exp=ffffffffffffffa5", data_o); end
    n_checks++; if (wbe_o !== 8'h01) begin n_fail++; $display("FAIL cout8_wbe got=%h exp=01", wbe_o); end
    drive(1'b1, 4'b0010, 8'h05, 64'h0, 8'b1000_0010, 64'h0000_0000_0000_00F0, 5'd8);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'h0000_0000_0000_00F1) begin n_fail++; $display("FAIL cout16_data got=%h exp=00000000000000f1", data_o); end
    n_checks++; if (wbe_o !== 8'h01) begin n_fail++; $display("FAIL cout16_wbe got=%h exp=01", wbe_o); end
    // 32-bit elements: element 1 takes carry of slot 7, element 0 keeps old (mask off).
    drive(1'b1, 4'b0100, 8'h02, 64'h0, 8'h80, 64'h0000_0000_0000_0001, 5'd9);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (data_o !== 64'h0000_0000_0000_0003) begin n_fail++; $display("FAIL cout32_data got=%h exp=0000000000000003", data_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    ready_i = 1'b0;
    drive(1'b0, 4'b0001, 8'hFF, 64'hA0A0_A0A0_A0A0_A0A0, 8'h00, 64'h0, 5'd10);
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || data_o !== 64'hA0A0_A0A0_A0A0_A0A0) begin n_fail++; $display("FAIL b2b_A_head valid=%b data=%h exp valid=1 data=a0a0a0a0a0a0a0a0", valid_o, data_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one got=%b exp=1", ready_o); end
    drive(1'b0, 4'b0001, 8'hFF, 64'hB0B0_B0B0_B0B0_B0B0, 8'h00, 64'h0, 5'd11);
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full got=%b exp=0", ready_o); end
    drive(1'b0, 4'b0001, 8'hFF, 64'hC0C0_C0C0_C0C0_C0C0, 8'h00, 64'h0, 5'd12);
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_stall got=%b exp=0", ready_o); end
      n_checks++; if (data_o !== 64'hA0A0_A0A0_A0A0_A0A0 || tag_o !== 5'd10 || wbe_o !== 8'hFF) begin n_fail++; $display("FAIL b2b_stall_hold data=%h tag=%0d wbe=%h exp data=a0a0a0a0a0a0a0a0 tag=10 wbe=ff", data_o, tag_o, wbe_o); end
    end
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || data_o !== 64'hB0B0_B0B0_B0B0_B0B0 || tag_o !== 5'd11) begin n_fail++; $display("FAIL b2b_B valid=%b data=%h tag=%0d exp valid=1 data=b0b0b0b0b0b0b0b0 tag=11", valid_o, data_o, tag_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got=%b exp=1", ready_o); end
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o !== 64'hC0C0_C0C0_C0C0_C0C0 || tag_o !== 5'd12) begin n_fail++; $display("FAIL b2b_C valid=%b data=%h tag=%0d exp valid=1 data=c0c0c0c0c0c0c0c0 tag=12", valid_o, data_o, tag_o); end
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got=%b exp=0", valid_o); end
  endtask

  task automatic test_flush;
    ready_i = 1'b0;
    drive(1'b0, 4'b0001, 8'hFF, 64'h1, 8'h00, 64'h0, 5'd13);
    @(negedge clk);
    drive(1'b0, 4'b0001, 8'hFF, 64'h2, 8'h00, 64'h0, 5'd14);
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_prefull got=%b exp=0", ready_o); end
    drive(1'b0, 4'b0001, 8'hFF, 64'hDDDD_DDDD_DDDD_DDDD, 8'h00, 64'h0, 5'd15);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped valid=%b data=%h exp valid=0", valid_o, data_o); end
    end
  endtask

  task automatic test_reset_mid;
    ready_i = 1'b0;
    drive(1'b0, 4'b0001, 8'hFF, 64'h3, 8'h00, 64'h0, 5'd16);
    @(negedge clk);
    drive(1'b0, 4'b0001, 8'hFF, 64'h4, 8'h00, 64'h0, 5'd17);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", valid_o); end
    n_checks++; if (data_o !== 64'h0) begin n_fail++; $display("FAIL rstmid_data got=%h exp=0", data_o); end
    n_checks++; if (wbe_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_wbe got=%h exp=00", wbe_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", ready_o); end
    ready_i = 1'b1;
    drive(1'b0, 4'b0001, 8'hFF, 64'hEEEE_0000_EEEE_0000, 8'h00, 64'h0, 5'd18);
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++; if (valid_o !== 1'b1 || data_o !== 64'hEEEE_0000_EEEE_0000 || tag_o !== 5'd18) begin n_fail++; $display("FAIL rstmid_beat valid=%b data=%h tag=%0d exp valid=1 data=eeee0000eeee0000 tag=18", valid_o, data_o, tag_o); end
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_drain got=%b exp=0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_carryout();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
